// File: rtl/axi_cdc_isolate_ctrl.sv
// Source-side quiesce/isolation controller for an AXI clock-domain crossing.
// Optional local DECERR responder while isolated: define AXI_CDC_ISOLATE_ERR_RESP_EN.
module axi_cdc_isolate_ctrl #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 16,
    localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    // Slave port (faces the upstream master)
    input  logic [ID_WIDTH-1:0] slv_awid,
    input  logic [31:0]         slv_awaddr,
    input  logic [7:0]          slv_awlen,
    input  logic [2:0]          slv_awsize,
    input  logic [1:0]          slv_awburst,
    input  logic                slv_awlock,
    input  logic [3:0]          slv_awcache,
    input  logic [2:0]          slv_awprot,
    input  logic [3:0]          slv_awqos,
    input  logic [3:0]          slv_awregion,
    input  logic                slv_awuser,
    input  logic                slv_awvalid,
    output logic                slv_awready,
    input  logic [63:0]         slv_wdata,
    input  logic [7:0]          slv_wstrb,
    input  logic                slv_wlast,
    input  logic                slv_wuser,
    input  logic                slv_wvalid,
    output logic                slv_wready,
    output logic [ID_WIDTH-1:0] slv_bid,
    output logic [1:0]          slv_bresp,
    output logic                slv_buser,
    output logic                slv_bvalid,
    input  logic                slv_bready,
    input  logic [ID_WIDTH-1:0] slv_arid,
    input  logic [31:0]         slv_araddr,
    input  logic [7:0]          slv_arlen,
    input  logic [2:0]          slv_arsize,
    input  logic [1:0]          slv_arburst,
    input  logic                slv_arlock,
    input  logic [3:0]          slv_arcache,
    input  logic [2:0]          slv_arprot,
    input  logic [3:0]          slv_arqos,
    input  logic [3:0]          slv_arregion,
    input  logic                slv_aruser,
    input  logic                slv_arvalid,
    output logic                slv_arready,
    output logic [ID_WIDTH-1:0] slv_rid,
    output logic [63:0]         slv_rdata,
    output logic [1:0]          slv_rresp,
    output logic                slv_rlast,
    output logic                slv_ruser,
    output logic                slv_rvalid,
    input  logic                slv_rready,

    // Master port (faces the CDC source port)
    output logic [ID_WIDTH-1:0] mst_awid,
    output logic [31:0]         mst_awaddr,
    output logic [7:0]          mst_awlen,
    output logic [2:0]          mst_awsize,
    output logic [1:0]          mst_awburst,
    output logic                mst_awlock,
    output logic [3:0]          mst_awcache,
    output logic [2:0]          mst_awprot,
    output logic [3:0]          mst_awqos,
    output logic [3:0]          mst_awregion,
    output logic                mst_awuser,
    output logic                mst_awvalid,
    input  logic                mst_awready,
    output logic [63:0]         mst_wdata,
    output logic [7:0]          mst_wstrb,
    output logic                mst_wlast,
    output logic                mst_wuser,
    output logic                mst_wvalid,
    input  logic                mst_wready,
    input  logic [ID_WIDTH-1:0] mst_bid,
    input  logic [1:0]          mst_bresp,
    input  logic                mst_buser,
    input  logic                mst_bvalid,
    output logic                mst_bready,
    output logic [ID_WIDTH-1:0] mst_arid,
    output logic [31:0]         mst_araddr,
    output logic [7:0]          mst_arlen,
    output logic [2:0]          mst_arsize,
    output logic [1:0]          mst_arburst,
    output logic                mst_arlock,
    output logic [3:0]          mst_arcache,
    output logic [2:0]          mst_arprot,
    output logic [3:0]          mst_arqos,
    output logic [3:0]          mst_arregion,
    output logic                mst_aruser,
    output logic                mst_arvalid,
    input  logic                mst_arready,
    input  logic [ID_WIDTH-1:0] mst_rid,
    input  logic [63:0]         mst_rdata,
    input  logic [1:0]          mst_rresp,
    input  logic                mst_rlast,
    input  logic                mst_ruser,
    input  logic                mst_rvalid,
    output logic                mst_rready,

    input  logic                isolate_req_i,
    output logic                isolated_o,
    output logic [CW-1:0]       wr_outstanding_o,
    output logic [CW-1:0]       rd_outstanding_o
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ISOLATED} state_e;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    state_e        state_q;
    logic          isolated_q;
    logic [CW-1:0] wr_cnt_q, rd_cnt_q, wpend_q;

    logic aw_block, ar_block, w_block;
    logic aw_inc, w_dec, b_dec, ar_inc, r_dec;
    logic local_busy, local_start;

    // Gating is a function of registered state only, so isolate_req_i never
    // reaches an AXI output combinationally.
    assign aw_block = (state_q != ST_RUN) || (wr_cnt_q == MAX_CNT) || (wpend_q == MAX_CNT);
    assign ar_block = (state_q != ST_RUN) || (rd_cnt_q == MAX_CNT);
    assign w_block  = (state_q == ST_ISOLATED) && (wpend_q == '0);

    assign mst_awid     = slv_awid;
    assign mst_awaddr   = slv_awaddr;
    assign mst_awlen    = slv_awlen;
    assign mst_awsize   = slv_awsize;
    assign mst_awburst  = slv_awburst;
    assign mst_awlock   = slv_awlock;
    assign mst_awcache  = slv_awcache;
    assign mst_awprot   = slv_awprot;
    assign mst_awqos    = slv_awqos;
    assign mst_awregion = slv_awregion;
    assign mst_awuser   = slv_awuser;
    assign mst_awvalid  = slv_awvalid && !aw_block;

    assign mst_wdata    = slv_wdata;
    assign mst_wstrb    = slv_wstrb;
    assign mst_wlast    = slv_wlast;
    assign mst_wuser    = slv_wuser;
    assign mst_wvalid   = slv_wvalid && !w_block;

    assign mst_arid     = slv_arid;
    assign mst_araddr   = slv_araddr;
    assign mst_arlen    = slv_arlen;
    assign mst_arsize   = slv_arsize;
    assign mst_arburst  = slv_arburst;
    assign mst_arlock   = slv_arlock;
    assign mst_arcache  = slv_arcache;
    assign mst_arprot   = slv_arprot;
    assign mst_arqos    = slv_arqos;
    assign mst_arregion = slv_arregion;
    assign mst_aruser   = slv_aruser;
    assign mst_arvalid  = slv_arvalid && !ar_block;

`ifdef AXI_CDC_ISOLATE_ERR_RESP_EN
    typedef enum logic [1:0] {LW_IDLE, LW_DATA, LW_RESP} lw_state_e;

    lw_state_e           lw_q;
    logic [ID_WIDTH-1:0] lw_id_q;
    logic                lr_active_q;
    logic [ID_WIDTH-1:0] lr_id_q;
    logic [7:0]          lr_len_q, lr_beat_q;
    logic                local_aw_ready, local_ar_ready, local_aw_hs, local_ar_hs;

    assign local_aw_ready = (state_q == ST_ISOLATED) && (lw_q == LW_IDLE);
    assign local_ar_ready = (state_q == ST_ISOLATED) && !lr_active_q;
    assign local_aw_hs    = slv_awvalid && local_aw_ready;
    assign local_ar_hs    = slv_arvalid && local_ar_ready;
    assign local_busy     = (lw_q != LW_IDLE) || lr_active_q;
    assign local_start    = local_aw_hs || local_ar_hs;

    assign slv_awready = aw_block ? local_aw_ready : mst_awready;
    assign slv_arready = ar_block ? local_ar_ready : mst_arready;
    assign slv_wready  = w_block ? (lw_q == LW_DATA) : mst_wready;

    assign slv_bvalid  = (lw_q == LW_RESP) || mst_bvalid;
    assign slv_bid     = (lw_q == LW_RESP) ? lw_id_q : mst_bid;
    assign slv_bresp   = (lw_q == LW_RESP) ? 2'b11 : mst_bresp;
    assign slv_buser   = (lw_q == LW_RESP) ? 1'b0 : mst_buser;
    assign mst_bready  = slv_bready && (lw_q != LW_RESP);

    assign slv_rvalid  = lr_active_q || mst_rvalid;
    assign slv_rid     = lr_active_q ? lr_id_q : mst_rid;
    assign slv_rdata   = lr_active_q ? 64'd0 : mst_rdata;
    assign slv_rresp   = lr_active_q ? 2'b11 : mst_rresp;
    assign slv_rlast   = lr_active_q ? (lr_beat_q == lr_len_q) : mst_rlast;
    assign slv_ruser   = lr_active_q ? 1'b0 : mst_ruser;
    assign mst_rready  = slv_rready && !lr_active_q;

    // Local write: accept AW, sink W through wlast, then answer one DECERR B.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lw_q    <= LW_IDLE;
            lw_id_q <= '0;
        end else begin
            case (lw_q)
                LW_IDLE: if (local_aw_hs) begin
                    lw_q    <= LW_DATA;
                    lw_id_q <= slv_awid;
                end
                LW_DATA: if (slv_wvalid && slv_wlast) lw_q <= LW_RESP;
                LW_RESP: if (slv_bready) lw_q <= LW_IDLE;
                default: lw_q <= LW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lr_active_q <= 1'b0;
            lr_id_q     <= '0;
            lr_len_q    <= '0;
            lr_beat_q   <= '0;
        end else if (!lr_active_q) begin
            if (local_ar_hs) begin
                lr_active_q <= 1'b1;
                lr_id_q     <= slv_arid;
                lr_len_q    <= slv_arlen;
                lr_beat_q   <= '0;
            end
        end else if (slv_rready) begin
            if (lr_beat_q == lr_len_q) lr_active_q <= 1'b0;
            else                       lr_beat_q   <= lr_beat_q + 8'd1;
        end
    end
`else
    assign local_busy  = 1'b0;
    assign local_start = 1'b0;

    assign slv_awready = mst_awready && !aw_block;
    assign slv_arready = mst_arready && !ar_block;
    assign slv_wready  = mst_wready && !w_block;

    assign slv_bvalid  = mst_bvalid;
    assign slv_bid     = mst_bid;
    assign slv_bresp   = mst_bresp;
    assign slv_buser   = mst_buser;
    assign mst_bready  = slv_bready;

    assign slv_rvalid  = mst_rvalid;
    assign slv_rid     = mst_rid;
    assign slv_rdata   = mst_rdata;
    assign slv_rresp   = mst_rresp;
    assign slv_rlast   = mst_rlast;
    assign slv_ruser   = mst_ruser;
    assign mst_rready  = slv_rready;
`endif

    // Counters track only traffic that really crosses the mst port.
    assign aw_inc = mst_awvalid && mst_awready;
    assign w_dec  = mst_wvalid && mst_wready && mst_wlast;
    assign b_dec  = mst_bvalid && mst_bready;
    assign ar_inc = mst_arvalid && mst_arready;
    assign r_dec  = mst_rvalid && mst_rready && mst_rlast;

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                               input logic inc, input logic dec);
        if (inc && !dec)                 return cnt + CW'(1);
        if (dec && !inc && cnt != '0)    return cnt - CW'(1);
        return cnt;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wpend_q  <= '0;
        end else begin
            wr_cnt_q <= cnt_next(wr_cnt_q, aw_inc, b_dec);
            rd_cnt_q <= cnt_next(rd_cnt_q, ar_inc, r_dec);
            wpend_q  <= cnt_next(wpend_q,  aw_inc, w_dec);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            isolated_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: if (isolate_req_i) state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!isolate_req_i) begin
                        state_q <= ST_RUN;
                    end else if (wr_cnt_q == '0 && rd_cnt_q == '0 && wpend_q == '0) begin
                        state_q    <= ST_ISOLATED;
                        isolated_q <= 1'b1;
                    end
                end
                ST_ISOLATED: begin
                    // A local response that is running or just accepted defers the exit.
                    if (!isolate_req_i && !local_busy && !local_start) begin
                        state_q    <= ST_RUN;
                        isolated_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    isolated_q <= 1'b0;
                end
            endcase
        end
    end

    assign isolated_o       = isolated_q;
    assign wr_outstanding_o = wr_cnt_q;
    assign rd_outstanding_o = rd_cnt_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(b_dec && !aw_inc && wr_cnt_q == '0)) else $error("wr_cnt underflow");
            assert (!(r_dec && !ar_inc && rd_cnt_q == '0)) else $error("rd_cnt underflow");
            assert (!(w_dec && !aw_inc && wpend_q == '0))  else $error("wpend underflow");
        end
    end
`endif

endmodule

// File: tb/tb_axi_cdc_isolate_ctrl.sv
// Directed bench for axi_cdc_isolate_ctrl: pass-through, limit, drain/isolate, abort, reset.
// Run with MAX_OUTSTANDING = 3 so one DUT covers both the drain (3 writes) and limit cases.
module tb_axi_cdc_isolate_ctrl;

    localparam int IW  = 4;
    localparam int MAX = 3;
    localparam int CW  = $clog2(MAX + 1);

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic [IW-1:0] slv_awid, slv_arid, slv_bid, slv_rid;
    logic [31:0]   slv_awaddr, slv_araddr;
    logic [7:0]    slv_awlen, slv_arlen, slv_wstrb;
    logic [2:0]    slv_awsize, slv_arsize, slv_awprot, slv_arprot;
    logic [1:0]    slv_awburst, slv_arburst, slv_bresp, slv_rresp;
    logic          slv_awlock, slv_arlock, slv_awuser, slv_aruser;
    logic [3:0]    slv_awcache, slv_arcache, slv_awqos, slv_arqos, slv_awregion, slv_arregion;
    logic          slv_awvalid, slv_awready, slv_arvalid, slv_arready;
    logic [63:0]   slv_wdata, slv_rdata;
    logic          slv_wlast, slv_wuser, slv_wvalid, slv_wready;
    logic          slv_buser, slv_bvalid, slv_bready;
    logic          slv_rlast, slv_ruser, slv_rvalid, slv_rready;

    logic [IW-1:0] mst_awid, mst_arid, mst_bid, mst_rid;
    logic [31:0]   mst_awaddr, mst_araddr;
    logic [7:0]    mst_awlen, mst_arlen, mst_wstrb;
    logic [2:0]    mst_awsize, mst_arsize, mst_awprot, mst_arprot;
    logic [1:0]    mst_awburst, mst_arburst, mst_bresp, mst_rresp;
    logic          mst_awlock, mst_arlock, mst_awuser, mst_aruser;
    logic [3:0]    mst_awcache, mst_arcache, mst_awqos, mst_arqos, mst_awregion, mst_arregion;
    logic          mst_awvalid, mst_awready, mst_arvalid, mst_arready;
    logic [63:0]   mst_wdata, mst_rdata;
    logic          mst_wlast, mst_wuser, mst_wvalid, mst_wready;
    logic          mst_buser, mst_bvalid, mst_bready;
    logic          mst_rlast, mst_ruser, mst_rvalid, mst_rready;

    logic          isolate_req_i, isolated_o;
    logic [CW-1:0] wr_outstanding_o, rd_outstanding_o;

    axi_cdc_isolate_ctrl #(.ID_WIDTH(IW), .MAX_OUTSTANDING(MAX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .slv_awid(slv_awid), .slv_awaddr(slv_awaddr), .slv_awlen(slv_awlen), .slv_awsize(slv_awsize),
        .slv_awburst(slv_awburst), .slv_awlock(slv_awlock), .slv_awcache(slv_awcache),
        .slv_awprot(slv_awprot), .slv_awqos(slv_awqos), .slv_awregion(slv_awregion),
        .slv_awuser(slv_awuser), .slv_awvalid(slv_awvalid), .slv_awready(slv_awready),
        .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_wlast(slv_wlast), .slv_wuser(slv_wuser),
        .slv_wvalid(slv_wvalid), .slv_wready(slv_wready),
        .slv_bid(slv_bid), .slv_bresp(slv_bresp), .slv_buser(slv_buser),
        .slv_bvalid(slv_bvalid), .slv_bready(slv_bready),
        .slv_arid(slv_arid), .slv_araddr(slv_araddr), .slv_arlen(slv_arlen), .slv_arsize(slv_arsize),
        .slv_arburst(slv_arburst), .slv_arlock(slv_arlock), .slv_arcache(slv_arcache),
        .slv_arprot(slv_arprot), .slv_arqos(slv_arqos), .slv_arregion(slv_arregion),
        .slv_aruser(slv_aruser), .slv_arvalid(slv_arvalid), .slv_arready(slv_arready),
        .slv_rid(slv_rid), .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rlast(slv_rlast),
        .slv_ruser(slv_ruser), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready),
        .mst_awid(mst_awid), .mst_awaddr(mst_awaddr), .mst_awlen(mst_awlen), .mst_awsize(mst_awsize),
        .mst_awburst(mst_awburst), .mst_awlock(mst_awlock), .mst_awcache(mst_awcache),
        .mst_awprot(mst_awprot), .mst_awqos(mst_awqos), .mst_awregion(mst_awregion),
        .mst_awuser(mst_awuser), .mst_awvalid(mst_awvalid), .mst_awready(mst_awready),
        .mst_wdata(mst_wdata), .mst_wstrb(mst_wstrb), .mst_wlast(mst_wlast), .mst_wuser(mst_wuser),
        .mst_wvalid(mst_wvalid), .mst_wready(mst_wready),
        .mst_bid(mst_bid), .mst_bresp(mst_bresp), .mst_buser(mst_buser),
        .mst_bvalid(mst_bvalid), .mst_bready(mst_bready),
        .mst_arid(mst_arid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
        .mst_arburst(mst_arburst), .mst_arlock(mst_arlock), .mst_arcache(mst_arcache),
        .mst_arprot(mst_arprot), .mst_arqos(mst_arqos), .mst_arregion(mst_arregion),
        .mst_aruser(mst_aruser), .mst_arvalid(mst_arvalid), .mst_arready(mst_arready),
        .mst_rid(mst_rid), .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
        .mst_ruser(mst_ruser), .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
        .isolate_req_i(isolate_req_i), .isolated_o(isolated_o),
        .wr_outstanding_o(wr_outstanding_o), .rd_outstanding_o(rd_outstanding_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        slv_awid = '0; slv_awaddr = '0; slv_awlen = '0; slv_awsize = '0; slv_awburst = '0;
        slv_awlock = 0; slv_awcache = '0; slv_awprot = '0; slv_awqos = '0; slv_awregion = '0;
        slv_awuser = 0; slv_awvalid = 0;
        slv_wdata = '0; slv_wstrb = '0; slv_wlast = 0; slv_wuser = 0; slv_wvalid = 0;
        slv_bready = 0;
        slv_arid = '0; slv_araddr = '0; slv_arlen = '0; slv_arsize = '0; slv_arburst = '0;
        slv_arlock = 0; slv_arcache = '0; slv_arprot = '0; slv_arqos = '0; slv_arregion = '0;
        slv_aruser = 0; slv_arvalid = 0;
        slv_rready = 0;
        mst_awready = 0; mst_wready = 0;
        mst_bid = '0; mst_bresp = '0; mst_buser = 0; mst_bvalid = 0;
        mst_arready = 0;
        mst_rid = '0; mst_rdata = '0; mst_rresp = '0; mst_rlast = 0; mst_ruser = 0; mst_rvalid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        isolate_req_i = 1'b0;
        clear_inputs();

        // ---- Reset state; AXI path follows inputs even in reset
        slv_awvalid = 1; mst_awready = 1;
        #2;
        check("rst_isolated", isolated_o, 0);
        check("rst_wr_cnt", wr_outstanding_o, 0);
        check("rst_rd_cnt", rd_outstanding_o, 0);
        check("rst_aw_follow", mst_awvalid, 1);
        check("rst_awready_follow", slv_awready, 1);
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // ---- Pass-through: 4-beat write
        step();
        slv_awid = 4'd3; slv_awaddr = 32'h1000; slv_awlen = 8'd3; slv_awvalid = 1; mst_awready = 1;
        #1;
        check("pt_aw_valid", mst_awvalid, 1);
        check("pt_aw_addr", mst_awaddr, 64'h1000);
        check("pt_aw_ready", slv_awready, 1);
        step();
        slv_awvalid = 0;
        check("pt_wr_cnt_1", wr_outstanding_o, 1);
        mst_wready = 1; slv_wvalid = 1;
        for (int i = 0; i < 4; i++) begin
            slv_wdata = 64'hA5A5_0000_0000_0000 + 64'(i);
            slv_wlast = (i == 3);
            #1;
            check("pt_w_data", mst_wdata, 64'hA5A5_0000_0000_0000 + 64'(i));
            check("pt_w_last", mst_wlast, (i == 3));
            step();
        end
        slv_wvalid = 0; slv_wlast = 0;
        mst_bvalid = 1; mst_bid = 4'd3; slv_bready = 1;
        #1;
        check("pt_b_valid", slv_bvalid, 1);
        check("pt_b_id", slv_bid, 3);
        step();
        mst_bvalid = 0;
        check("pt_wr_cnt_0", wr_outstanding_o, 0);

        // ---- Pass-through: 8-beat read
        slv_arid = 4'd2; slv_araddr = 32'h2000; slv_arlen = 8'd7; slv_arvalid = 1; mst_arready = 1;
        #1;
        check("pt_ar_valid", mst_arvalid, 1);
        check("pt_ar_len", mst_arlen, 7);
        step();
        slv_arvalid = 0;
        check("pt_rd_cnt_1", rd_outstanding_o, 1);
        mst_rvalid = 1; slv_rready = 1; mst_rid = 4'd2;
        for (int i = 0; i < 8; i++) begin
            mst_rdata = 64'h0BAD_0000_0000_0000 + 64'(i);
            mst_rlast = (i == 7);
            #1;
            check("pt_r_data", slv_rdata, 64'h0BAD_0000_0000_0000 + 64'(i));
            check("pt_r_last", slv_rlast, (i == 7));
            step();
        end
        mst_rvalid = 0; mst_rlast = 0;
        check("pt_rd_cnt_0", rd_outstanding_o, 0);

        // ---- Limit: 3 reads fill the counter, 4th AR waits for an rlast
        clear_inputs();
        slv_arlen = 8'd0; slv_arvalid = 1; mst_arready = 1;
        repeat (3) step();
        check("lim_rd_cnt_full", rd_outstanding_o, 3);
        check("lim_arready_gated", slv_arready, 0);
        check("lim_mst_ar_gated", mst_arvalid, 0);
        step();
        check("lim_still_gated", slv_arready, 0);
        slv_rready = 1; mst_rvalid = 1; mst_rlast = 1;
        #1;
        check("lim_gated_during_rlast", slv_arready, 0);
        step();
        check("lim_rd_cnt_after_rlast", rd_outstanding_o, 2);
        check("lim_arready_released", slv_arready, 1);
        check("lim_mst_ar_released", mst_arvalid, 1);
        step();
        slv_arvalid = 0;
        check("lim_simul_inc_dec", rd_outstanding_o, 2);
        repeat (2) step();
        mst_rvalid = 0; mst_rlast = 0;
        check("lim_rd_cnt_0", rd_outstanding_o, 0);

        // ---- Drain: 3 writes + 2 reads outstanding
        clear_inputs();
        mst_awready = 1; mst_wready = 1; mst_arready = 1;
        slv_awvalid = 1; slv_wvalid = 1; slv_wlast = 1;
        repeat (3) step();
        slv_awvalid = 0; slv_wvalid = 0; slv_wlast = 0;
        slv_arvalid = 1;
        repeat (2) step();
        slv_arvalid = 0;
        check("dr_wr_cnt", wr_outstanding_o, 3);
        check("dr_rd_cnt", rd_outstanding_o, 2);
        isolate_req_i = 1;
        step();
        slv_awvalid = 1; slv_arvalid = 1;
        #1;
        check("dr_ar_blocked", mst_arvalid, 0);
        check("dr_arready_low", slv_arready, 0);
        check("dr_aw_blocked", mst_awvalid, 0);
        check("dr_not_isolated", isolated_o, 0);
        slv_bready = 1; slv_rready = 1;
        for (int i = 0; i < 3; i++) begin
            repeat (2) step();
            mst_bvalid = 1; mst_bid = IW'(i + 1);
            #1;
            check("dr_no_ar_during_b", mst_arvalid, 0);
            step();
            mst_bvalid = 0;
            check("dr_wr_cnt_dec", wr_outstanding_o, 64'(2 - i));
        end
        for (int i = 0; i < 2; i++) begin
            repeat (3) step();
            mst_rvalid = 1; mst_rlast = 1;
            #1;
            check("dr_no_aw_during_r", mst_awvalid, 0);
            step();
            mst_rvalid = 0; mst_rlast = 0;
            check("dr_rd_cnt_dec", rd_outstanding_o, 64'(1 - i));
        end
        slv_awvalid = 0; slv_arvalid = 0;
        check("dr_iso_not_yet", isolated_o, 0);
        step();
        check("dr_isolated", isolated_o, 1);

`ifdef AXI_CDC_ISOLATE_ERR_RESP_EN
        // ---- Local DECERR read while isolated
        slv_arid = 4'd5; slv_arlen = 8'd3; slv_arvalid = 1;
        #1;
        check("err_arready", slv_arready, 1);
        check("err_no_mst_ar", mst_arvalid, 0);
        step();
        slv_arvalid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("err_rvalid", slv_rvalid, 1);
            check("err_rresp", slv_rresp, 3);
            check("err_rid", slv_rid, 5);
            check("err_rdata", slv_rdata, 0);
            check("err_rlast", slv_rlast, (i == 3));
            check("err_no_mst_ar_burst", mst_arvalid, 0);
            step();
        end
        check("err_r_done", slv_rvalid, 0);
`else
        // ---- Isolated without local responder: AR stalls indefinitely
        slv_arid = 4'd5; slv_arlen = 8'd3; slv_arvalid = 1;
        #1;
        check("iso_arready_low", slv_arready, 0);
        check("iso_no_mst_ar", mst_arvalid, 0);
        repeat (3) step();
        check("iso_arready_still_low", slv_arready, 0);
        check("iso_still_isolated", isolated_o, 1);
        slv_arvalid = 0;
`endif

        // ---- Release from isolation
        isolate_req_i = 0;
        #1;
        check("rel_isolated_hold", isolated_o, 1);
        step();
        check("rel_isolated_clear", isolated_o, 0);

        // ---- Abort: 2-cycle pulse with wr_cnt = 1, pending AW accepted after release
        clear_inputs();
        mst_awready = 1; mst_wready = 1;
        slv_awid = 4'd7; slv_awvalid = 1; slv_wvalid = 1; slv_wlast = 1;
        step();
        slv_awvalid = 0; slv_wvalid = 0; slv_wlast = 0;
        check("ab_wr_cnt_1", wr_outstanding_o, 1);
        isolate_req_i = 1;
        step();
        slv_awid = 4'd8; slv_awlen = 8'd1; slv_awvalid = 1;
        #1;
        check("ab_aw_held", slv_awready, 0);
        check("ab_mst_aw_low", mst_awvalid, 0);
        check("ab_no_iso_1", isolated_o, 0);
        step();
        isolate_req_i = 0;
        #1;
        check("ab_aw_held_2", slv_awready, 0);
        check("ab_no_iso_2", isolated_o, 0);
        step();
        check("ab_aw_accept", slv_awready, 1);
        check("ab_mst_aw_pass", mst_awvalid, 1);
        check("ab_no_iso_3", isolated_o, 0);
        step();
        slv_awvalid = 0;
        check("ab_wr_cnt_2", wr_outstanding_o, 2);

        // ---- Reset mid-burst
        slv_wvalid = 1; slv_wlast = 0;
        step();
        slv_wvalid = 0;
        isolate_req_i = 1;
        step();
        isolate_req_i = 0;
        slv_awvalid = 1;
        rst_ni = 1'b0;
        #1;
        check("mrst_wr_cnt", wr_outstanding_o, 0);
        check("mrst_rd_cnt", rd_outstanding_o, 0);
        check("mrst_isolated", isolated_o, 0);
        check("mrst_run_aw", mst_awvalid, 1);
        slv_awvalid = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step();
        slv_awvalid = 1;
        #1;
        check("post_rst_run_aw", mst_awvalid, 1);
        slv_awvalid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
